// File: rtl/game_pkg.sv
// Shared state encodings and helpers for the rhythm-game sequencer.
package game_pkg;
  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_CLEAR     = 3'd1;
  localparam logic [ST_W-1:0] ST_COUNTDOWN = 3'd2;
  localparam logic [ST_W-1:0] ST_PLAY      = 3'd3;
  localparam logic [ST_W-1:0] ST_RESULT    = 3'd4;

  localparam int DEF_TICKS_PER_S = 1000;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/tick_counter.sv
// Enabled up-counter with synchronous clear; at MAX it either holds (sat) or wraps to zero.
module tick_counter #(
  parameter int WIDTH = 11,
  parameter int MAX   = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_sat,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_at_max
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      if (cnt_q == MAX_V) cnt_d = i_sat ? cnt_q : '0;
      else                cnt_d = cnt_q + WIDTH'(1);
    end
  end

  assign o_cnt    = cnt_q;
  assign o_at_max = (cnt_q == MAX_V);
endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: IDLE -> CLEAR -> COUNTDOWN -> PLAY -> RESULT, with soft-clear,
// restart/abort handling and gating of the 1 ms tick into the game timer.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int COUNTDOWN_S    = 3,
  parameter int TICKS_PER_S    = DEF_TICKS_PER_S,
  parameter int RESULT_HOLD_MS = 2000,
  parameter int CLR_CYC        = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_tick,
  input  logic            i_start,
  input  logic            i_restart,
  input  logic            i_game_end,
  output logic [ST_W-1:0] o_state,
  output logic            o_soft_clr,
  output logic            o_gated_tick,
  output logic            o_game_run,
  output logic            o_game_over,
  output logic [1:0]      o_countdown
);
  localparam int MS_W  = $clog2(imax(TICKS_PER_S, RESULT_HOLD_MS) + 1);
  localparam int CLR_W = $clog2(CLR_CYC + 1);

  localparam logic [MS_W-1:0]  TPS_LAST = MS_W'(TICKS_PER_S - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);
  localparam logic [1:0]       SEC_INIT = 2'(COUNTDOWN_S);

  logic [ST_W-1:0]  state_q, state_d;
  logic [1:0]       sec_q, sec_d;
  logic [CLR_W-1:0] clr_q, clr_d;
  logic             end_prev_q;

  logic             ms_clr, ms_en, ms_sat, ms_at_max;
  logic [MS_W-1:0]  ms_cnt;
  logic             end_rise;

  assign end_rise = i_game_end & ~end_prev_q;
  assign ms_sat   = (state_q == ST_RESULT);

  // The ms counter saturates at the RESULT hold time; the COUNTDOWN second
  // boundary is produced by clearing it at TICKS_PER_S-1, so it never needs
  // to wrap on its own as long as TICKS_PER_S-1 <= RESULT_HOLD_MS.
  tick_counter #(
    .WIDTH (MS_W),
    .MAX   (RESULT_HOLD_MS)
  ) u_ms_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (ms_clr),
    .i_en     (ms_en),
    .i_sat    (ms_sat),
    .o_cnt    (ms_cnt),
    .o_at_max (ms_at_max)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sec_q      <= '0;
      clr_q      <= '0;
      end_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      clr_q      <= clr_d;
      end_prev_q <= i_game_end;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    clr_d   = '0;
    ms_clr  = 1'b0;
    ms_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr_d = clr_q + CLR_W'(1);
        if (clr_q == CLR_LAST) begin
          state_d = ST_COUNTDOWN;
          sec_d   = SEC_INIT;
          ms_clr  = 1'b1;
        end
      end
      ST_COUNTDOWN: begin
        if (i_restart) begin
          state_d = ST_CLEAR;
        end else if (i_tick) begin
          if (ms_cnt == TPS_LAST) begin
            ms_clr = 1'b1;
            sec_d  = sec_q - 2'd1;
            if (sec_q == 2'd1) state_d = ST_PLAY;
          end else begin
            ms_en = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (i_restart) begin
          state_d = ST_CLEAR;
        end else if (end_rise) begin
          state_d = ST_RESULT;
          ms_clr  = 1'b1;
        end
      end
      ST_RESULT: begin
        ms_en = i_tick;
        if (i_restart && ms_at_max) state_d = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_state      = state_q;
    o_soft_clr   = (state_q == ST_CLEAR);
    o_game_run   = (state_q == ST_PLAY);
    o_game_over  = (state_q == ST_RESULT);
    o_countdown  = (state_q == ST_COUNTDOWN) ? sec_q : 2'd0;
    o_gated_tick = i_tick & (state_q == ST_PLAY);
  end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus random traffic, checked every
// cycle against a tick-counting behavioural model of the game flow.
module tb_game_flow_ctrl;
  localparam int CD   = 3;
  localparam int TPS  = 10;
  localparam int HOLD = 20;
  localparam int CLRC = 4;

  localparam int M_IDLE = 0, M_CLEAR = 1, M_CD = 2, M_PLAY = 3, M_RES = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_tick = 1'b0, i_start = 1'b0, i_restart = 1'b0, i_game_end = 1'b0;
  logic [2:0] o_state;
  logic       o_soft_clr, o_gated_tick, o_game_run, o_game_over;
  logic [1:0] o_countdown;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  game_flow_ctrl #(
    .COUNTDOWN_S    (CD),
    .TICKS_PER_S    (TPS),
    .RESULT_HOLD_MS (HOLD),
    .CLR_CYC        (CLRC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_tick       (i_tick),
    .i_start      (i_start),
    .i_restart    (i_restart),
    .i_game_end   (i_game_end),
    .o_state      (o_state),
    .o_soft_clr   (o_soft_clr),
    .o_gated_tick (o_gated_tick),
    .o_game_run   (o_game_run),
    .o_game_over  (o_game_over),
    .o_countdown  (o_countdown)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase plus elapsed-cycle / elapsed-tick counts.
  int  m_st = M_IDLE;
  int  m_clr_cycles = 0;
  int  m_cd_ticks = 0;
  int  m_res_ticks = 0;
  bit  m_prev_end = 1'b0;

  always @(posedge clk) begin : model
    int nxt;
    bit rise;
    if (!rst) begin
      m_st = M_IDLE; m_clr_cycles = 0; m_cd_ticks = 0; m_res_ticks = 0; m_prev_end = 1'b0;
    end else begin
      rise = i_game_end && !m_prev_end;
      nxt  = m_st;
      case (m_st)
        M_IDLE: if (i_start) begin nxt = M_CLEAR; m_clr_cycles = 0; end
        M_CLEAR: begin
          m_clr_cycles++;
          if (m_clr_cycles == CLRC) begin nxt = M_CD; m_cd_ticks = 0; end
        end
        M_CD: begin
          if (i_restart) begin nxt = M_CLEAR; m_clr_cycles = 0; end
          else if (i_tick) begin
            m_cd_ticks++;
            if (m_cd_ticks == CD * TPS) nxt = M_PLAY;
          end
        end
        M_PLAY: begin
          if (i_restart) begin nxt = M_CLEAR; m_clr_cycles = 0; end
          else if (rise) begin nxt = M_RES; m_res_ticks = 0; end
        end
        M_RES: begin
          if (i_restart && m_res_ticks >= HOLD) begin nxt = M_CLEAR; m_clr_cycles = 0; end
          else if (i_tick && m_res_ticks < HOLD) m_res_ticks++;
        end
        default: nxt = M_IDLE;
      endcase
      m_st = nxt;
      m_prev_end = i_game_end;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(o_state), m_st);
      chk("soft_clr", int'(o_soft_clr), int'(m_st == M_CLEAR));
      chk("game_run", int'(o_game_run), int'(m_st == M_PLAY));
      chk("game_over", int'(o_game_over), int'(m_st == M_RES));
      chk("countdown", int'(o_countdown), (m_st == M_CD) ? CD - m_cd_ticks / TPS : 0);
      chk("gated_tick", int'(o_gated_tick), int'(i_tick && m_st == M_PLAY));
    end
  end

  task automatic drive(input bit t, input bit s, input bit r);
    i_tick = t; i_start = s; i_restart = r;
    @(posedge clk); #2;
    i_tick = 1'b0; i_start = 1'b0; i_restart = 1'b0;
  endtask

  task automatic to_play();
    for (int i = 0; i < CLRC; i++) drive(0, 0, 0);
    for (int i = 0; i < CD * TPS; i++) begin drive(1, 0, 0); drive(0, 0, 0); end
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    chk("rst_state", int'(o_state), 0);
    chk("rst_cd", int'(o_countdown), 0);
    rst = 1'b1;
    drive(0, 0, 1);
    chk("idle_ignores_restart", int'(o_state), 0);

    // Start, soft-clear width, countdown entry
    drive(0, 1, 0);
    chk("start_to_clear", int'(o_state), 1);
    for (int i = 0; i < CLRC - 1; i++) begin
      drive(0, 0, 0);
      chk("clear_held", int'(o_soft_clr), 1);
    end
    drive(0, 0, 0);
    chk("clear_done", int'(o_state), 2);
    chk("cd_init", int'(o_countdown), 3);

    // Countdown seconds
    for (int k = 1; k <= CD * TPS; k++) begin
      drive(1, 0, 0);
      if (k == 9)  chk("cd_tick9", int'(o_countdown), 3);
      if (k == 10) chk("cd_tick10", int'(o_countdown), 2);
      if (k == 20) chk("cd_tick20", int'(o_countdown), 1);
      if (k == 29) chk("cd_tick29", int'(o_state), 2);
      drive(0, 0, 0);
    end
    chk("play_entered", int'(o_state), 3);

    // End edge with a same-cycle tick
    i_game_end = 1'b1; i_tick = 1'b1;
    #1 chk("gated_in_play", int'(o_gated_tick), 1);
    @(posedge clk); #2; i_tick = 1'b0;
    chk("end_to_result", int'(o_state), 4);
    chk("over_high", int'(o_game_over), 1);

    // Result hold before restart
    for (int i = 0; i < 5; i++) drive(1, 0, 0);
    drive(0, 1, 1);
    chk("early_restart_ignored", int'(o_state), 4);
    for (int i = 0; i < 15; i++) drive(1, 0, 0);
    drive(0, 0, 1);
    chk("restart_after_hold", int'(o_state), 1);
    chk("restart_clear_pulse", int'(o_soft_clr), 1);

    // Stale high end level must not end the new game
    to_play();
    chk("stale_end_play", int'(o_state), 3);
    for (int i = 0; i < 5; i++) drive(1, 0, 0);
    chk("stale_end_still_play", int'(o_state), 3);
    i_game_end = 1'b0; drive(0, 0, 0);
    chk("end_low_play", int'(o_state), 3);
    i_game_end = 1'b1; drive(0, 0, 0);
    chk("fresh_end_result", int'(o_state), 4);
    for (int i = 0; i < HOLD + 3; i++) drive(1, 0, 0);
    i_game_end = 1'b0;
    drive(0, 0, 1);
    chk("result_restart2", int'(o_state), 1);
    to_play();

    // Restart beats simultaneous end edge
    i_game_end = 1'b1;
    drive(0, 0, 1);
    chk("restart_wins", int'(o_state), 1);
    to_play();
    chk("play_again", int'(o_state), 3);

    // One-cycle reset mid-game
    rst = 1'b0; @(posedge clk); #2; rst = 1'b1;
    chk("abort_state", int'(o_state), 0);
    chk("abort_run", int'(o_game_run), 0);
    chk("abort_soft_clr", int'(o_soft_clr), 0);
    drive(0, 0, 0);
    chk("abort_no_clear", int'(o_soft_clr), 0);
    drive(0, 1, 0);
    chk("start_after_abort", int'(o_state), 1);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      i_tick    = ($urandom_range(0, 99) < 45);
      i_start   = ($urandom_range(0, 99) < 6);
      i_restart = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 3) i_game_end = ~i_game_end;
      rst = ($urandom_range(0, 499) != 0);
      @(posedge clk); #2;
    end
    rst = 1'b1; i_tick = 1'b0; i_start = 1'b0; i_restart = 1'b0;
    @(posedge clk); #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
